// File: rtl/ram_loader.sv
// Byte-stream to 16-bit RAM loader: packs pairs of stream bytes into words and
// writes them to consecutive ram16k addresses starting at a captured base.
module ram_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] base_addr,
  input  logic [14:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic [14:0] words_written
);

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StWrite,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [14:0] count_q, count_d;
  logic [14:0] written_q, written_d;
  logic [7:0]  first_q, first_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic        done_q, done_d;
  logic [14:0] written_inc;

  // Handshake readiness depends on state only, so no valid->ready loop exists.
  assign byte_ready    = (state_q == StGetA) || (state_q == StGetB);
  assign busy          = (state_q != StIdle);
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_we        = mem_we_q;
  assign done          = done_q;
  assign words_written = written_q;

  assign written_inc = written_q + 15'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    written_d  = written_q;
    first_d    = first_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d    = base_addr;
          count_d   = word_count;
          written_d = '0;
          if (word_count == '0) begin
            state_d = StFinish;
            done_d  = 1'b1;
          end else begin
            state_d = StGetA;
          end
        end
      end
      StGetA: begin
        if (byte_valid) begin
          first_d = byte_in;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (byte_valid) begin
          // Write strobe, address and data are loaded together so they are
          // all registered and aligned with the WRITE state.
          mem_data_d = MSB_FIRST ? {first_q, byte_in} : {byte_in, first_q};
          mem_addr_d = addr_q;
          mem_we_d   = 1'b1;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        addr_d    = addr_q + 14'd1;
        written_d = written_inc;
        if (written_inc == count_q) begin
          state_d = StFinish;
          done_d  = 1'b1;
        end else begin
          state_d = StGetA;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      written_q  <= '0;
      first_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      written_q  <= written_d;
      first_q    <= first_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: an MSB-first and an LSB-first instance
// share one stimulus stream and are checked against a word-level model.
module tb_ram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, byte_valid;
  logic [13:0] base_addr;
  logic [14:0] word_count;
  logic [7:0]  byte_in;

  logic        byte_ready_m, mem_we_m, busy_m, done_m;
  logic [13:0] mem_addr_m;
  logic [15:0] mem_data_m;
  logic [14:0] words_written_m;
  logic        byte_ready_l, mem_we_l, busy_l, done_l;
  logic [13:0] mem_addr_l;
  logic [15:0] mem_data_l;
  logic [14:0] words_written_l;

  ram_loader #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_m), .mem_addr(mem_addr_m), .mem_data(mem_data_m),
    .mem_we(mem_we_m), .busy(busy_m), .done(done_m), .words_written(words_written_m)
  );

  ram_loader #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_l), .mem_addr(mem_addr_l), .mem_data(mem_data_l),
    .mem_we(mem_we_l), .busy(busy_l), .done(done_l), .words_written(words_written_l)
  );

  logic [48:0] outs_m, outs_l;
  assign outs_m = {mem_we_m, mem_addr_m, mem_data_m, busy_m, done_m, byte_ready_m,
                   words_written_m};
  assign outs_l = {mem_we_l, mem_addr_l, mem_data_l, busy_l, done_l, byte_ready_l,
                   words_written_l};

  int checks = 0;
  int passes = 0;
  int hang = 0;
  int done_cnt_m = 0;
  int done_cnt_l = 0;
  int we_err = 0;
  logic we_prev_m = 1'b0;
  logic we_prev_l = 1'b0;
  logic [29:0] act_m[$];
  logic [29:0] act_l[$];
  logic [15:0] ram_m[16384];
  logic [15:0] ram_l[16384];
  logic [7:0]  stim[$];

  // Behavioural ram16k plus write/done observers for both instances.
  always @(negedge clk) begin
    if (mem_we_m) begin
      act_m.push_back({mem_addr_m, mem_data_m});
      ram_m[mem_addr_m] <= mem_data_m;
    end
    if (mem_we_l) begin
      act_l.push_back({mem_addr_l, mem_data_l});
      ram_l[mem_addr_l] <= mem_data_l;
    end
    if ((mem_we_m && we_prev_m) || (mem_we_l && we_prev_l)) we_err <= we_err + 1;
    we_prev_m <= mem_we_m;
    we_prev_l <= mem_we_l;
    if (done_m) done_cnt_m <= done_cnt_m + 1;
    if (done_l) done_cnt_l <= done_cnt_l + 1;
  end

  // Word i of a run lands at (base+i) mod 16384, bytes paired in stream order.
  function automatic logic [29:0] model_word(input int base, input int i, input bit msb);
    int a, d;
    a = (base + i) % 16384;
    if (msb) d = int'(stim[2*i]) * 256 + int'(stim[2*i+1]);
    else     d = int'(stim[2*i+1]) * 256 + int'(stim[2*i]);
    return {a[13:0], d[15:0]};
  endfunction

  task automatic scramble();
    base_addr  = 14'($urandom);
    word_count = 15'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t;
    repeat (gap) begin
      byte_valid = 1'b0;
      start = 1'b0;
      scramble();
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in = b;
    start = poke;
    scramble();
    t = 0;
    while (byte_ready_m !== 1'b1 && t < 20) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 20) hang++;
    @(negedge clk);
  endtask

  task automatic run_load(input int base, input int count, input int max_gap, input bit poke,
                          input string name);
    int t, dm, dl, werr0, bad, bad_i, cyc;
    time t0;
    logic [29:0] em, el, gm, gl;
    act_m.delete();
    act_l.delete();
    dm = done_cnt_m;
    dl = done_cnt_l;
    werr0 = we_err;
    hang = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 14'(base);
    word_count = 15'(count);
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t0 = $time;
    checks++;
    if (busy_m !== 1'b1 || busy_l !== 1'b1 || words_written_m !== 15'd0 ||
        words_written_l !== 15'd0)
      $display("FAIL %s start_accept: busy=%b/%b words_written=%0d/%0d, required 1/1 0/0",
               name, busy_m, busy_l, words_written_m, words_written_l);
    else passes++;
    for (int i = 0; i < 2 * count; i++)
      send_byte(stim[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)),
                poke && (i == 3));
    byte_valid = 1'b0;
    start = 1'b0;
    t = 0;
    while ((busy_m || busy_l) && t < 40) begin
      @(negedge clk);
      t++;
    end
    cyc = int'(($time - t0) / 10);
    checks++;
    if (hang != 0 || t >= 40)
      $display("FAIL %s handshake: stalled bytes=%0d finish_wait=%0d, required 0 stalls", name,
               hang, t);
    else passes++;
    checks++;
    if (done_cnt_m - dm != 1 || done_cnt_l - dl != 1)
      $display("FAIL %s done_pulses: got %0d/%0d, required 1", name, done_cnt_m - dm,
               done_cnt_l - dl);
    else passes++;
    checks++;
    if (words_written_m !== 15'(count) || words_written_l !== 15'(count))
      $display("FAIL %s words_written: got %0d/%0d, required %0d", name, words_written_m,
               words_written_l, count);
    else passes++;
    checks++;
    if (act_m.size() != count || act_l.size() != count)
      $display("FAIL %s write_count: got %0d/%0d, required %0d", name, act_m.size(),
               act_l.size(), count);
    else passes++;
    if (count > 0) begin
      bad = 0;
      bad_i = 0;
      for (int i = 0; i < count && i < act_m.size() && i < act_l.size(); i++) begin
        em = model_word(base, i, 1'b1);
        el = model_word(base, i, 1'b0);
        if (act_m[i] !== em || act_l[i] !== el) begin
          if (bad == 0) bad_i = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        gm = act_m[bad_i];
        gl = act_l[bad_i];
        em = model_word(base, bad_i, 1'b1);
        el = model_word(base, bad_i, 1'b0);
        $display("FAIL %s write_data: word %0d got %h/%h, required %h/%h (addr,data)", name,
                 bad_i, gm, gl, em, el);
      end else passes++;
      bad = 0;
      for (int i = 0; i < count; i++) begin
        em = model_word(base, i, 1'b1);
        el = model_word(base, i, 1'b0);
        if (ram_m[em[29:16]] !== em[15:0] || ram_l[el[29:16]] !== el[15:0]) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL %s ram_readback: %0d words differ, required 0", name, bad);
      else passes++;
    end
    checks++;
    if (we_err != werr0 || mem_we_m !== 1'b0 || mem_we_l !== 1'b0)
      $display("FAIL %s we_width: long pulses=%0d idle_we=%b/%b, required 0 0/0", name,
               we_err - werr0, mem_we_m, mem_we_l);
    else passes++;
    if (max_gap == 0) begin
      checks++;
      if (cyc != 3 * count + 1)
        $display("FAIL %s throughput: busy cycles %0d, required %0d", name, cyc, 3 * count + 1);
      else passes++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (outs_m !== '0 || outs_l !== '0)
      $display("FAIL reset_state: outputs %h/%h, required 0", outs_m, outs_l);
    else passes++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0 || byte_ready_m !== 1'b0 || done_m !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b/%b ready=%b done=%b, required 0", busy_m, busy_l,
               byte_ready_m, done_m);
    else passes++;
  endtask

  task automatic test_scenario1();
    stim = '{8'hA5, 8'hA5, 8'hF0, 8'hF0};
    run_load(0, 2, 0, 1'b0, "msb_basic");
    checks++;
    if (ram_m[0] !== 16'hA5A5 || ram_m[1] !== 16'hF0F0)
      $display("FAIL msb_basic_ram: got %h %h, required a5a5 f0f0", ram_m[0], ram_m[1]);
    else passes++;
  endtask

  task automatic test_wrap();
    stim = '{8'h5A, 8'h5A, 8'h12, 8'h34};
    run_load(16'h3FFF, 2, 0, 1'b0, "wrap");
    checks++;
    if (ram_m[16383] !== 16'h5A5A || ram_m[0] !== 16'h1234)
      $display("FAIL wrap_ram: got %h %h, required 5a5a 1234", ram_m[16383], ram_m[0]);
    else passes++;
  endtask

  task automatic test_zero();
    stim.delete();
    run_load(int'($urandom_range(16383, 0)), 0, 0, 1'b0, "zero_count");
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 4; r++) begin
      stim.delete();
      for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
      run_load(int'($urandom_range(16383, 0)), int'($urandom_range(6, 2)), 5, 1'b1, "gaps");
    end
  endtask

  task automatic test_reset_mid();
    int dm, dl;
    act_m.delete();
    act_l.delete();
    dm = done_cnt_m;
    dl = done_cnt_l;
    @(negedge clk);
    start = 1'b1;
    base_addr = 14'h0155;
    word_count = 15'd2;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h3C, 0, 1'b0);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs_m !== '0 || outs_l !== '0)
      $display("FAIL reset_in_get_b: outputs %h/%h, required 0", outs_m, outs_l);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (act_m.size() != 0 || act_l.size() != 0 || done_cnt_m != dm || done_cnt_l != dl ||
        busy_m !== 1'b0)
      $display("FAIL abort_get_b: writes=%0d/%0d dones=%0d busy=%b, required 0 0 0",
               act_m.size(), act_l.size(), done_cnt_m - dm, busy_m);
    else passes++;
    @(negedge clk);
    start = 1'b1;
    base_addr = 14'h2AAA;
    word_count = 15'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h81, 0, 1'b0);
    send_byte(8'h7E, 0, 1'b0);
    byte_valid = 1'b0;
    checks++;
    if (mem_we_m !== 1'b1 || mem_we_l !== 1'b1)
      $display("FAIL write_reached: mem_we=%b/%b, required 1", mem_we_m, mem_we_l);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_we_m !== 1'b0 || mem_we_l !== 1'b0 || busy_m !== 1'b0 || mem_data_m !== 16'h0)
      $display("FAIL we_cut: mem_we=%b/%b busy=%b data=%h, required 0", mem_we_m, mem_we_l,
               busy_m, mem_data_m);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt_m != dm || done_cnt_l != dl)
      $display("FAIL abort_no_done: dones=%0d/%0d, required 0", done_cnt_m - dm,
               done_cnt_l - dl);
    else passes++;
    stim = '{8'($urandom), 8'($urandom)};
    run_load(int'($urandom_range(16383, 0)), 1, 3, 1'b0, "after_reset");
  endtask

  task automatic test_lsb();
    stim = '{8'h34, 8'h12};
    run_load(int'($urandom_range(16383, 0)), 1, 2, 1'b0, "lsb");
    checks++;
    if (mem_data_l !== 16'h1234 || mem_data_m !== 16'h3412)
      $display("FAIL lsb_word: got %h/%h, required 1234 (lsb) 3412 (msb)", mem_data_l,
               mem_data_m);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(8'($urandom));
      run_load(int'($urandom_range(16383, 0)), 5, 0, 1'b0, "back_to_back");
    end
  endtask

  task automatic test_full();
    stim.delete();
    for (int i = 0; i < 32768; i++) stim.push_back(8'($urandom));
    run_load(int'($urandom_range(16383, 1)), 16384, 0, 1'b0, "full_16k");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = '0;
    base_addr = '0;
    word_count = '0;
    test_reset();
    test_scenario1();
    test_wrap();
    test_zero();
    test_gaps();
    test_reset_mid();
    test_lsb();
    test_back_to_back();
    test_full();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
